// File: rtl/vert_timing.sv
// Vertical timing for 640x480@60 VGA: line counter, phase FSM, VS, blanking and pixel coordinates.
// Optional frame counter built when VERT_TIMING_FRAME_CNT_EN is defined.
module vert_timing #(
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACTIVE    = 640,
    parameter logic        VS_POL      = 1'b1
) (
    input  logic        clk25M,
    input  logic        rst_n,
    input  logic        termcount,
    input  logic [9:0]  hcount,
    output logic        VS,
    output logic [9:0]  vcount,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [9:0] LAST_SYNC = 10'(V_SYNC - 1);
    localparam logic [9:0] LAST_BP   = 10'(V_SYNC + V_BP - 1);
    localparam logic [9:0] ACT_LINE0 = 10'(V_SYNC + V_BP);
    localparam logic [9:0] LAST_ACT  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] LAST_LINE = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [9:0] H_START   = 10'(H_ACT_START);
    localparam logic [9:0] H_END     = 10'(H_ACT_START + H_ACTIVE);

    localparam logic [1:0] PH_SYNC   = 2'd0;
    localparam logic [1:0] PH_BP     = 2'd1;
    localparam logic [1:0] PH_ACTIVE = 2'd2;
    localparam logic [1:0] PH_FP     = 2'd3;

    logic [9:0] vcount_q, vcount_d;
    logic [1:0] phase_q, phase_d;
    logic       term_q;
    logic       vs_q, vs_d;
    logic       frame_start_q;
    logic       line_adv;
    logic       wrap;

    // Rising edge of termcount so a stretched pulse advances only one line
    assign line_adv = termcount & ~term_q;
    assign wrap     = line_adv && (vcount_q == LAST_LINE);

    always_comb begin
        vcount_d = vcount_q;
        phase_d  = phase_q;
        if (line_adv) begin
            vcount_d = wrap ? 10'd0 : vcount_q + 10'd1;
            case (phase_q)
                PH_SYNC:   if (vcount_q == LAST_SYNC) phase_d = PH_BP;
                PH_BP:     if (vcount_q == LAST_BP)   phase_d = PH_ACTIVE;
                PH_ACTIVE: if (vcount_q == LAST_ACT)  phase_d = PH_FP;
                PH_FP:     if (wrap)                  phase_d = PH_SYNC;
                default: begin
                    phase_d  = PH_SYNC;
                    vcount_d = 10'd0;
                end
            endcase
        end
        vs_d = (phase_d == PH_SYNC) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            vcount_q      <= 10'd0;
            phase_q       <= PH_SYNC;
            term_q        <= 1'b0;
            vs_q          <= VS_POL;
            frame_start_q <= 1'b0;
        end else begin
            vcount_q      <= vcount_d;
            phase_q       <= phase_d;
            term_q        <= termcount;
            vs_q          <= vs_d;
            frame_start_q <= wrap;
        end
    end

`ifdef VERT_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'h0000;
        end else if (wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'h0001;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

    assign vcount      = vcount_q;
    assign VS          = vs_q;
    assign frame_start = frame_start_q;

    assign video_on = (phase_q == PH_ACTIVE) && (hcount >= H_START) && (hcount < H_END);
    assign pixel_x  = video_on ? (hcount - H_START) : 10'd0;
    assign pixel_y  = video_on ? 9'(vcount_q - ACT_LINE0) : 9'd0;

endmodule

// File: tb/tb_vert_timing.sv
// Directed self-checking bench for vert_timing; lines are compressed to two clocks where
// only the vertical behaviour matters.
module tb_vert_timing;

    logic        clk25M = 1'b0;
    logic        rst_n;
    logic        termcount;
    logic [9:0]  hcount;
    logic        VS;
    logic [9:0]  vcount;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic        frame_start;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

`ifdef VERT_TIMING_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    vert_timing dut (
        .clk25M      (clk25M),
        .rst_n       (rst_n),
        .termcount   (termcount),
        .hcount      (hcount),
        .VS          (VS),
        .vcount      (vcount),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #20 clk25M = ~clk25M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25M);
        #1;
    endtask

    // One compressed line: hcount=799 with termcount, then hcount=0
    task automatic adv_line();
        hcount    = 10'd799;
        termcount = 1'b1;
        tick();
        hcount    = 10'd0;
        termcount = 1'b0;
        tick();
    endtask

    task automatic adv_lines(input int n);
        for (int i = 0; i < n; i++) adv_line();
    endtask

    task automatic probe(input int h);
        hcount = 10'(h);
        #1;
    endtask

    int vs_cnt;
    int fs_cnt;

    initial begin
        rst_n     = 1'b0;
        termcount = 1'b0;
        hcount    = 10'd200;
        tick();
        tick();
        tick();
        check("rst_vcount", vcount, 0);
        check("rst_vs", VS, 1);
        check("rst_video_on", video_on, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_pixel_x", pixel_x, 0);
        check("rst_pixel_y", pixel_y, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // Two real 800-clock lines: VS high throughout, no frame_start
        rst_n  = 1'b1;
        vs_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            hcount    = 10'(i % 800);
            termcount = ((i % 800) == 799);
            #1;
            if (VS) vs_cnt++;
            if (frame_start) fs_cnt++;
            tick();
        end
        check("sync_vs_clocks", vs_cnt, 1600);
        check("sync_no_frame_start", fs_cnt, 0);
        hcount    = 10'd0;
        termcount = 1'b0;
        #1;
        check("line2_vcount", vcount, 2);
        check("line2_vs_low", VS, 0);
        tick();

        // Stretched termcount at line 10
        adv_lines(8);
        check("line10_vcount", vcount, 10);
        hcount    = 10'd799;
        termcount = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        hcount    = 10'd0;
        termcount = 1'b0;
        tick();
        check("stretch_vcount", vcount, 11);
        probe(200);
        check("stretch_bp_blank", video_on, 0);
        check("stretch_vs", VS, 0);

        // Top-left corner of the window
        adv_lines(24);
        check("line35_vcount", vcount, 35);
        probe(143);
        check("tl_left_blank", video_on, 0);
        probe(144);
        check("tl_video_on", video_on, 1);
        check("tl_pixel_x", pixel_x, 0);
        check("tl_pixel_y", pixel_y, 0);
        probe(400);
        check("mid_pixel_x", pixel_x, 256);

        // Bottom-right corner
        adv_lines(479);
        check("line514_vcount", vcount, 514);
        probe(783);
        check("br_video_on", video_on, 1);
        check("br_pixel_x", pixel_x, 639);
        check("br_pixel_y", pixel_y, 479);
        probe(784);
        check("br_right_blank", video_on, 0);
        check("br_blank_pixel_x", pixel_x, 0);
        probe(900);
        check("hcount_oob_blank", video_on, 0);

        adv_line();
        check("line515_vcount", vcount, 515);
        probe(144);
        check("fp_blank_left", video_on, 0);
        probe(500);
        check("fp_blank_mid", video_on, 0);
        check("fp_pixel_y", pixel_y, 0);

        // Frame wrap
        adv_lines(9);
        check("line524_vcount", vcount, 524);
        check("line524_frame_start", frame_start, 0);
        hcount    = 10'd799;
        termcount = 1'b1;
        tick();
        hcount    = 10'd0;
        termcount = 1'b0;
        #1;
        check("wrap_vcount", vcount, 0);
        check("wrap_frame_start", frame_start, 1);
        check("wrap_vs", VS, 1);
        check("wrap_frame_cnt", frame_cnt, FC_EN ? 1 : 0);
        tick();
        check("wrap_frame_start_drop", frame_start, 0);

        // Mid-frame asynchronous reset
        adv_lines(300);
        check("line300_vcount", vcount, 300);
        check("line300_vs", VS, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_vcount", vcount, 0);
        check("async_rst_vs", VS, 1);
        check("async_rst_frame_cnt", frame_cnt, 0);
        tick();
        rst_n = 1'b1;
        check("post_rst_frame_start", frame_start, 0);

        adv_lines(524);
        check("post_rst_line524", vcount, 524);
        check("post_rst_no_fs", frame_start, 0);
        hcount    = 10'd799;
        termcount = 1'b1;
        tick();
        hcount    = 10'd0;
        termcount = 1'b0;
        #1;
        check("post_rst_wrap_vcount", vcount, 0);
        check("post_rst_wrap_fs", frame_start, 1);
        tick();

        adv_lines(1050);
        check("three_frames_vcount", vcount, 0);
        check("three_frames_cnt", frame_cnt, FC_EN ? 3 : 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
